lmb_bram_dp: RTL

Parametrised single-clock true-dual-port local-memory BRAM for the MicroBlaze LMB subsystem, the successor to the fixed 64 KiB/32-bit elaborate block. It is generic in size, data width and read latency, and supports a selectable same-port write mode. It zero-fills the array after reset and resolves and counts cross-port address collisions. Port A serves the data-side LMB controller and port B the instruction-side controller.

---
 rtl/lmb_bram_pkg.sv | 30 +++
 rtl/lmb_bram_dp_if.sv | 25 ++
 rtl/lmb_bram_byte_ram.sv | 57 +++++
 rtl/lmb_bram_dp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lmb_bram_pkg.sv
// Shared definitions for the LMB dual-port local-memory BRAM.
package lmb_bram_pkg;

  // Zero-fill sequencer states
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bram_state_e;

  // Width of the saturating collision counter
  localparam int CNT_W = 16;

  // Same-port read-during-write selections
  localparam string WM_READ_FIRST  = "READ_FIRST";
  localparam string WM_WRITE_FIRST = "WRITE_FIRST";

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int res;
    int val;
    res = 0;
    val = value - 1;
    while (val > 0) begin
      res = res + 1;
      val = val >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lmb_bram_dp_if.sv
// One LMB-side BRAM port: enable, byte write enables, byte address and data.
// Vectors are MSB-first ([0] is the most significant bit / byte).
interface lmb_bram_dp_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int NWE = DW / 8
) ();

  logic          BRAM_EN;
  logic [0:NWE-1] BRAM_WEN;
  logic [0:AW-1] BRAM_Addr;
  logic [0:DW-1] BRAM_Dout;   // write data from the controller
  logic [0:DW-1] BRAM_Din;    // read data to the controller

  modport master (
    output BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout,
    input  BRAM_Din
  );

  modport slave (
    input  BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout,
    output BRAM_Din
  );

endinterface

// File: rtl/lmb_bram_byte_ram.sv
// Single byte lane of the dual-port memory. Storage has no reset so it maps
// onto block RAM; only the read-data registers are reset.
module lmb_bram_byte_ram #(
  parameter int IDX_W       = 8,
  parameter int DEPTH       = 256,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ena_i,
  input  logic             wea_i,
  input  logic [IDX_W-1:0] addra_i,
  input  logic [7:0]       dina_i,
  output logic [7:0]       douta_o,
  input  logic             enb_i,
  input  logic             web_i,
  input  logic [IDX_W-1:0] addrb_i,
  input  logic [7:0]       dinb_i,
  output logic [7:0]       doutb_o
);

  logic [7:0] mem_q [0:DEPTH-1];
  logic [7:0] douta_q;
  logic [7:0] doutb_q;

  // Array writes from both ports; the top never enables both on one word
  always_ff @(posedge clk_i) begin
    if (wea_i) begin
      mem_q[addra_i] <= dina_i;
    end
    if (web_i) begin
      mem_q[addrb_i] <= dinb_i;
    end
  end

  // Port A read register: old byte, or own new byte in write-first mode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      douta_q <= 8'h00;
    end else if (ena_i) begin
      douta_q <= (WRITE_FIRST && wea_i) ? dina_i : mem_q[addra_i];
    end
  end

  // Port B read register: old byte, or own new byte in write-first mode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      doutb_q <= 8'h00;
    end else if (enb_i) begin
      doutb_q <= (WRITE_FIRST && web_i) ? dinb_i : mem_q[addrb_i];
    end
  end

  assign douta_o = douta_q;
  assign doutb_o = doutb_q;

endmodule

// File: rtl/lmb_bram_dp.sv
// Parametrised true-dual-port LMB local memory. Port A serves the data side,
// port B the instruction side. The array is zero-filled after reset; cross-port
// collisions are resolved (A wins on shared bytes) and counted.
module lmb_bram_dp
  import lmb_bram_pkg::*;
#(
  parameter int    C_MEMSIZE      = 32'h0001_0000,
  parameter int    C_PORT_DWIDTH  = 32,
  parameter int    C_PORT_AWIDTH  = 32,
  parameter int    C_NUM_WE       = C_PORT_DWIDTH / 8,
  parameter int    C_READ_LATENCY = 1,
  parameter string C_WRITE_MODE   = WM_READ_FIRST
) (
  input  logic             BRAM_Clk,
  input  logic             BRAM_Rst_N,
  lmb_bram_dp_if.slave     port_a,
  lmb_bram_dp_if.slave     port_b,
  output logic             Init_Done,
  output logic             Collision,
  output logic [0:CNT_W-1] Collision_Cnt
);

  localparam int MEM_W  = clog2(C_MEMSIZE);
  localparam int BYTE_W = clog2(C_NUM_WE);
  localparam int IDX_W  = MEM_W - BYTE_W;
  localparam int DEPTH  = C_MEMSIZE / C_NUM_WE;
  localparam bit WF     = (C_WRITE_MODE == WM_WRITE_FIRST);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bram_state_e               state_q;
  logic [IDX_W-1:0]          fill_q;
  logic                      init_done_q;
  logic                      col_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      run_s;
  logic                      acc_a_s;
  logic                      acc_b_s;
  logic                      col_s;
  logic [IDX_W-1:0]          idx_a_s;
  logic [IDX_W-1:0]          idx_b_s;
  logic [IDX_W-1:0]          ram_addr_a_s;
  logic [0:C_NUM_WE-1]       ram_we_a_s;
  logic [0:C_NUM_WE-1]       ram_we_b_s;
  logic [0:C_PORT_DWIDTH-1]  ram_wdata_a_s;
  logic [0:C_PORT_DWIDTH-1]  rd_a_s;
  logic [0:C_PORT_DWIDTH-1]  rd_b_s;
  logic                      unused_addr_s;

  // Word index: bits above the memory size alias, byte-offset bits are dropped
  assign idx_a_s = port_a.BRAM_Addr[C_PORT_AWIDTH-MEM_W +: IDX_W];
  assign idx_b_s = port_b.BRAM_Addr[C_PORT_AWIDTH-MEM_W +: IDX_W];
  assign unused_addr_s = ^{port_a.BRAM_Addr, port_b.BRAM_Addr};

  assign run_s   = (state_q == ST_RUN);
  assign acc_a_s = run_s & port_a.BRAM_EN;
  assign acc_b_s = run_s & port_b.BRAM_EN;
  assign col_s   = acc_a_s & acc_b_s & (idx_a_s == idx_b_s) &
                   ((|port_a.BRAM_WEN) | (|port_b.BRAM_WEN));

  // Zero-fill sequencer: one word per cycle, then hand the array to the ports
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      state_q     <= ST_INIT;
      fill_q      <= {IDX_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (fill_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            fill_q <= fill_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          fill_q      <= {IDX_W{1'b0}};
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Steer port A to the fill counter during init; mask B bytes that A also writes
  always_comb begin
    ram_addr_a_s  = fill_q;
    ram_wdata_a_s = {C_PORT_DWIDTH{1'b0}};
    ram_we_a_s    = {C_NUM_WE{1'b1}};
    ram_we_b_s    = {C_NUM_WE{1'b0}};
    if (run_s) begin
      ram_addr_a_s  = idx_a_s;
      ram_wdata_a_s = port_a.BRAM_Dout;
      for (int i = 0; i < C_NUM_WE; i++) begin
        ram_we_a_s[i] = acc_a_s & port_a.BRAM_WEN[i];
        ram_we_b_s[i] = acc_b_s & port_b.BRAM_WEN[i] & ~(col_s & port_a.BRAM_WEN[i]);
      end
    end else begin
      ram_addr_a_s  = fill_q;
      ram_wdata_a_s = {C_PORT_DWIDTH{1'b0}};
      ram_we_a_s    = {C_NUM_WE{1'b1}};
      ram_we_b_s    = {C_NUM_WE{1'b0}};
    end
  end

  for (genvar g = 0; g < C_NUM_WE; g++) begin : g_lane
    lmb_bram_byte_ram #(
      .IDX_W       (IDX_W),
      .DEPTH       (DEPTH),
      .WRITE_FIRST (WF)
    ) u_lane (
      .clk_i   (BRAM_Clk),
      .rst_ni  (BRAM_Rst_N),
      .ena_i   (acc_a_s),
      .wea_i   (ram_we_a_s[g]),
      .addra_i (ram_addr_a_s),
      .dina_i  (ram_wdata_a_s[8*g +: 8]),
      .douta_o (rd_a_s[8*g +: 8]),
      .enb_i   (acc_b_s),
      .web_i   (ram_we_b_s[g]),
      .addrb_i (idx_b_s),
      .dinb_i  (port_b.BRAM_Dout[8*g +: 8]),
      .doutb_o (rd_b_s[8*g +: 8])
    );
  end

  if (C_READ_LATENCY == 2) begin : g_lat2
    logic                     vld_a_q;
    logic                     vld_b_q;
    logic [0:C_PORT_DWIDTH-1] out_a_q;
    logic [0:C_PORT_DWIDTH-1] out_b_q;

    // Extra output stage, loaded only behind an accepted access so data holds
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
      if (!BRAM_Rst_N) begin
        vld_a_q <= 1'b0;
        vld_b_q <= 1'b0;
        out_a_q <= {C_PORT_DWIDTH{1'b0}};
        out_b_q <= {C_PORT_DWIDTH{1'b0}};
      end else begin
        vld_a_q <= acc_a_s;
        vld_b_q <= acc_b_s;
        if (vld_a_q) begin
          out_a_q <= rd_a_s;
        end
        if (vld_b_q) begin
          out_b_q <= rd_b_s;
        end
      end
    end

    assign port_a.BRAM_Din = out_a_q;
    assign port_b.BRAM_Din = out_b_q;
  end else begin : g_lat1
    assign port_a.BRAM_Din = rd_a_s;
    assign port_b.BRAM_Din = rd_b_s;
  end

  // Collision pulse and saturating collision counter
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      col_q <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      col_q <= col_s;
      if (col_s && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign Init_Done     = init_done_q;
  assign Collision     = col_q;
  assign Collision_Cnt = cnt_q;

endmodule
